// File: rtl/stream_buffer_flushable_pkg.sv
// rtl/stream_buffer_flushable_pkg.sv - handshake operation encoding for the flushable stream buffer
package stream_buffer_flushable_pkg;

    // Encoded as {push, pop} so the vector maps straight onto the enum.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } buf_op_e;

endpackage

// File: rtl/stream_buffer_flushable.sv
// rtl/stream_buffer_flushable.sv - Depth-entry elastic valid/ready buffer with flush, clear and occupancy
module stream_buffer_flushable
    import stream_buffer_flushable_pkg::*;
#(
    parameter type         T      = logic,
    parameter int unsigned Depth  = 2,
    parameter bit          Bypass = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  T                           data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output T                           data_o,
    output logic [$clog2(Depth+1)-1:0] usage_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    if (Depth < 2) begin : g_depth_check
        $error("stream_buffer_flushable: Depth must be >= 2");
    end

    if (Bypass) begin : g_bypass
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
        assign usage_o = '0;
    end else begin : g_buffer
        T                r_mem [Depth];
        logic [PtrW-1:0] r_wptr;
        logic [PtrW-1:0] r_rptr;
        logic [CntW-1:0] r_cnt;
        logic [PtrW-1:0] w_wptr_nxt;
        logic [PtrW-1:0] w_rptr_nxt;
        logic [CntW-1:0] w_cnt_nxt;
        logic            w_push;
        logic            w_pop;
        buf_op_e         w_op;

        // Handshake outputs come from registered state only, so no input-to-output path exists.
        assign ready_o = (r_cnt != CntW'(Depth));
        assign valid_o = (r_cnt != '0);
        assign data_o  = r_mem[r_rptr];
        assign usage_o = r_cnt;

        assign w_push = valid_i && ready_o && !flush_i;
        assign w_pop  = valid_o && ready_i && !flush_i;
        assign w_op   = buf_op_e'({w_push, w_pop});

        always_comb begin
            w_wptr_nxt = r_wptr;
            w_rptr_nxt = r_rptr;
            w_cnt_nxt  = r_cnt;
            if (flush_i) begin
                w_rptr_nxt = r_wptr;
                w_cnt_nxt  = '0;
            end else begin
                // Explicit compare-to-last wrap keeps non-power-of-two depths correct.
                if (w_push) begin
                    w_wptr_nxt = (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
                end
                if (w_pop) begin
                    w_rptr_nxt = (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
                end
                case (w_op)
                    OP_PUSH: w_cnt_nxt = r_cnt + 1'b1;
                    OP_POP:  w_cnt_nxt = r_cnt - 1'b1;
                    default: w_cnt_nxt = r_cnt;
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else if (clr_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                r_wptr <= w_wptr_nxt;
                r_rptr <= w_rptr_nxt;
                r_cnt  <= w_cnt_nxt;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
            end else if (clr_i) begin
                for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
            end else if (w_push) begin
                r_mem[r_wptr] <= data_i;
            end
        end

        always @(posedge clk_i) begin
            if (rst_ni) begin
                assert (!(flush_i && valid_i))
                    else $warning("stream_buffer_flushable: valid_i during flush_i, input word dropped");
            end
        end
    end

endmodule

// File: tb/tb_stream_buffer_flushable.sv
// tb/tb_stream_buffer_flushable.sv - directed self-checking bench for stream_buffer_flushable
module tb_stream_buffer_flushable;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Depth=2 instance
    logic  clr2 = 0, fl2 = 0, v2 = 0, r2 = 0, vo2, ro2;
    byte_t d2 = 0, do2;
    logic [1:0] u2;
    // Depth=4 instance
    logic  clr4 = 0, fl4 = 0, v4 = 0, r4 = 0, vo4, ro4;
    byte_t d4 = 0, do4;
    logic [2:0] u4;
    // Depth=3 instance
    logic  clr3 = 0, fl3 = 0, v3 = 0, r3 = 0, vo3, ro3;
    byte_t d3 = 0, do3;
    logic [1:0] u3;
    // Bypass instance
    logic  clrb = 0, flb = 0, vb = 0, rb = 0, vob, rob;
    byte_t db = 0, dob;
    logic [1:0] ub;

    stream_buffer_flushable #(.T(byte_t), .Depth(2), .Bypass(1'b0)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr2), .flush_i(fl2),
        .valid_i(v2), .ready_o(ro2), .data_i(d2),
        .valid_o(vo2), .ready_i(r2), .data_o(do2), .usage_o(u2));

    stream_buffer_flushable #(.T(byte_t), .Depth(4), .Bypass(1'b0)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr4), .flush_i(fl4),
        .valid_i(v4), .ready_o(ro4), .data_i(d4),
        .valid_o(vo4), .ready_i(r4), .data_o(do4), .usage_o(u4));

    stream_buffer_flushable #(.T(byte_t), .Depth(3), .Bypass(1'b0)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr3), .flush_i(fl3),
        .valid_i(v3), .ready_o(ro3), .data_i(d3),
        .valid_o(vo3), .ready_i(r3), .data_o(do3), .usage_o(u3));

    stream_buffer_flushable #(.T(byte_t), .Depth(2), .Bypass(1'b1)) u_byp (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clrb), .flush_i(flb),
        .valid_i(vb), .ready_o(rob), .data_i(db),
        .valid_o(vob), .ready_i(rb), .data_o(dob), .usage_o(ub));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    byte_t fill4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rst_valid", vo2, 0);
        check("rst_ready", ro2, 1);
        check("rst_usage", u2, 0);
        check("rst_data", do2, 0);

        // Depth=4: fill with downstream stalled
        for (int i = 0; i < 4; i++) begin
            v4 = 1; d4 = fill4[i];
            tick();
            check($sformatf("fill_usage%0d", i), u4, i + 1);
        end
        check("full_ready", ro4, 0);
        check("full_head", do4, 8'h11);
        d4 = 8'h55;
        tick();
        check("full_no_accept", u4, 4);
        v4 = 0; r4 = 1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid%0d", i), vo4, 1);
            check($sformatf("drain_data%0d", i), do4, fill4[i]);
            tick();
            if (i == 0) check("ready_after_pop", ro4, 1);
        end
        check("drained_valid", vo4, 0);
        check("drained_usage", u4, 0);

        // Depth=3: continuous stream, pointers wrap repeatedly
        r3 = 1;
        for (int k = 0; k < 10; k++) begin
            v3 = 1; d3 = byte_t'(k);
            tick();
            check($sformatf("stream_valid%0d", k), vo3, 1);
            check($sformatf("stream_data%0d", k), do3, k);
            check($sformatf("stream_usage%0d", k), u3, 1);
        end
        v3 = 0;
        tick();
        check("stream_end_valid", vo3, 0);
        check("stream_end_usage", u3, 0);

        // Depth=4: flush with three entries held and ready_i high
        r4 = 0;
        for (int i = 0; i < 3; i++) begin
            v4 = 1; d4 = byte_t'(8'h0A + i);
            tick();
        end
        v4 = 0;
        check("pre_flush_usage", u4, 3);
        check("pre_flush_head", do4, 8'h0A);
        fl4 = 1; r4 = 1;
        tick();
        fl4 = 0; r4 = 0;
        check("flush_valid", vo4, 0);
        check("flush_usage", u4, 0);
        check("flush_ready", ro4, 1);
        v4 = 1; d4 = 8'h0D;
        tick();
        v4 = 0;
        check("post_flush_usage", u4, 1);
        check("post_flush_data", do4, 8'h0D);
        r4 = 1;
        tick();
        check("post_flush_empty", vo4, 0);

        // Depth=2: clear and flush together while full with valid_i high
        for (int i = 0; i < 2; i++) begin
            v2 = 1; d2 = byte_t'(8'h66 + 8'h11 * i);
            tick();
        end
        check("d2_full_usage", u2, 2);
        check("d2_full_ready", ro2, 0);
        clr2 = 1; fl2 = 1; v2 = 1; d2 = 8'h99;
        tick();
        clr2 = 0; fl2 = 0; v2 = 0;
        check("clr_valid", vo2, 0);
        check("clr_usage", u2, 0);
        check("clr_data", do2, 0);
        check("clr_ready", ro2, 1);
        v2 = 1; d2 = 8'h12;
        tick();
        v2 = 0;
        check("post_clr_data", do2, 8'h12);
        check("post_clr_usage", u2, 1);

        // Bypass: combinational pass-through, flush ignored
        vb = 1; rb = 0; db = 8'h5A; flb = 1;
        #1;
        check("byp_valid_a", vob, 1);
        check("byp_ready_a", rob, 0);
        check("byp_data_a", dob, 8'h5A);
        check("byp_usage_a", ub, 0);
        vb = 0; rb = 1; db = 8'hC3;
        #1;
        check("byp_valid_b", vob, 0);
        check("byp_ready_b", rob, 1);
        check("byp_data_b", dob, 8'hC3);
        flb = 0;
        tick();
        check("byp_usage_b", ub, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
